usb_edge_detect_multi: RTL and testbench
========================================

Name: usb_edge_detect_multi

Overview:
- Parametrised multi-channel transition detector for the USB receive front end.
- Takes already-synchronised line samples (D+, D-, or other bus lines) and applies a per-channel glitch filter of configurable length.
- Emits single-cycle edge pulses qualified per channel by a runtime mode: off, rising, falling or both.
- Keeps a saturating, clearable edge counter per channel for link-activity and resume detection.

Parameters:
- NUM_CH, 2, number of independent line channels (>=1).
- FILTER_LEN, 3, consecutive cycles a new level must hold before it is accepted (>=1).
- CNT_W, 8, width of each per-channel edge counter (>=1).
- IDLE_VAL, 1, reset value of every filtered level (USB J/idle on D+ = 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- d_in  input  NUM_CH  synchronised raw line samples; bit c = channel c.
- mode  input  2*NUM_CH  per-channel qualifier; bits [2c+1:2c]: 00 off, 01 rising, 10 falling, 11 both.
- cnt_clr  input  NUM_CH  per-channel synchronous clear of edge_count.
- d_filt  output  NUM_CH  registered filtered line level.
- d_edge  output  NUM_CH  registered one-cycle pulse per qualified filtered transition.
- any_edge  output  1  combinational OR of d_edge.
- edge_count  output  NUM_CH*CNT_W  per-channel saturating count; channel c at bits [c*CNT_W +: CNT_W].

Behaviour:
- Clock and reset: clock clk; reset n_rst, asynchronous, active-low.
- Reset values: d_filt = all IDLE_VAL; d_edge = 0; edge_count = 0; filter counters = 0; any_edge = 0.
- Filter, per channel, each cycle:
  - if d_in[c] == d_filt[c]: stability counter <= 0.
  - else if counter == FILTER_LEN-1: d_filt[c] <= d_in[c], counter <= 0 (accepted transition).
  - else: counter <= counter+1.
  - Counter width: $clog2(FILTER_LEN), minimum 1 bit.
- Latency: d_in[c] changes and holds from sampling edge k; d_filt[c] and d_edge[c] update at edge k+FILTER_LEN-1.
  - FILTER_LEN=1 gives one registered cycle of latency (update at edge k).
- Glitch rejection: any excursion shorter than FILTER_LEN cycles returns the counter to 0; no d_filt change, no pulse.
- Filter runs regardless of mode; d_filt always tracks the line.
- Edge qualification: an accepted 0->1 transition is rising; 1->0 is falling.
  - d_edge[c] <= 1 for exactly one cycle if the transition type is enabled by mode[2c+1:2c], sampled in the cycle of acceptance; else 0.
- Mode change: takes effect on the next accepted transition; never generates a pulse by itself.
- Back-to-back transitions (FILTER_LEN=1, toggling input): d_edge may stay high on consecutive cycles, one pulse per transition.
- Edge counter, per channel, priority order:
  - cnt_clr and qualified edge in the same cycle -> count = 1.
  - cnt_clr only -> count = 0.
  - qualified edge -> count+1, saturating at 2^CNT_W-1 (no wrap).
  - otherwise hold.
- Channels are fully independent; simultaneous edges on several channels are each pulsed and counted.
- Reset mid-operation: all state returns to reset values immediately.
  - A partially-filtered transition is discarded.
  - After release, a line already at IDLE_VAL produces no edge.

Test Plan:
- Use NUM_CH=2, FILTER_LEN=3, CNT_W=4, IDLE_VAL=1 for all scenarios.
- Reset: assert n_rst=0 with d_in=2'b00 -> d_filt=2'b11, d_edge=0, any_edge=0, edge_count=0. Release, hold d_in=2'b11 for 10 cycles -> no pulses.
- Falling, mode both: mode[1:0]=11, drive d_in[0] 1->0 and hold -> at the 3rd clock after the change, d_filt[0]=0, d_edge[0]=1 for one cycle, any_edge=1, edge_count[3:0]=1. Channel 1 is unaffected.
- Glitch: d_in[0] low for 2 cycles then high -> d_filt[0] stays 1, no pulse, count unchanged. A following 3-cycle low is accepted.
- Rising only: mode[1:0]=01, falling then rising transitions, each held 5 cycles -> d_filt follows both, one d_edge[0] pulse (on rising), count +1.
- Saturation/clear: 20 qualified edges on channel 1 -> edge_count[7:4]=15 held. Assert cnt_clr[1] in the same cycle as a qualified edge -> count=1. cnt_clr alone -> 0.
- Reset mid-filter: d_in[0] low for 2 cycles (counter=2), pulse n_rst low, raise d_in[0] before release -> no pulse, d_filt[0]=1, counter=0.

Source files
------------

// File: rtl/usb_edge_detect_multi.sv
// usb_edge_detect_multi
// Multi-channel glitch-filtered transition detector for the USB receive front end.
// Each channel filters its synchronised line sample. A new level is accepted only
// after it has held for FILTER_LEN cycles. Each accepted transition that matches
// the channel's mode produces a one-cycle pulse and bumps a saturating,
// clearable activity counter.

module usb_edge_detect_multi #(
    parameter int   NUM_CH     = 2,
    parameter int   FILTER_LEN = 3,
    parameter int   CNT_W      = 8,
    parameter logic IDLE_VAL   = 1'b1
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_CH-1:0]       d_in,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [NUM_CH-1:0]       cnt_clr,
    output logic [NUM_CH-1:0]       d_filt,
    output logic [NUM_CH-1:0]       d_edge,
    output logic                    any_edge,
    output logic [NUM_CH*CNT_W-1:0] edge_count
);

    // Stability counter must reach FILTER_LEN-1; keep at least one bit so FILTER_LEN=1 still elaborates
    localparam int              FCW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCW-1:0]  STAB_LIM = FCW'(FILTER_LEN - 1);

    logic [FCW-1:0]   r_stab [NUM_CH];
    logic [CNT_W-1:0] r_cnt  [NUM_CH];
    logic [NUM_CH-1:0] r_filt;
    logic [NUM_CH-1:0] r_edge;
    logic [NUM_CH-1:0] w_accept;
    logic [NUM_CH-1:0] w_qual;

    // Decide per channel whether this cycle accepts a new level and whether mode wants that direction
    always_comb begin
        w_accept = '0;
        w_qual   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_accept[c] = (d_in[c] != r_filt[c]) && (r_stab[c] == STAB_LIM);
            w_qual[c]   = w_accept[c] && (d_in[c] ? mode[2*c] : mode[2*c+1]);
        end
    end

    // Glitch filter: count consecutive disagreeing cycles, any agreement restarts the count
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_filt <= {NUM_CH{IDLE_VAL}};
            r_edge <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_stab[c] <= '0;
            end
        end else begin
            r_edge <= w_qual;
            for (int c = 0; c < NUM_CH; c++) begin
                if (d_in[c] == r_filt[c]) begin
                    r_stab[c] <= '0;
                end else if (w_accept[c]) begin
                    r_filt[c] <= d_in[c];
                    r_stab[c] <= '0;
                end else begin
                    r_stab[c] <= r_stab[c] + FCW'(1);
                end
            end
        end
    end

    // Activity counters: a clear coinciding with an edge leaves the edge counted, otherwise saturate
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cnt_clr[c] && w_qual[c]) begin
                    r_cnt[c] <= CNT_W'(1);
                end else if (cnt_clr[c]) begin
                    r_cnt[c] <= '0;
                end else if (w_qual[c] && (r_cnt[c] != {CNT_W{1'b1}})) begin
                    r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    // Pack the per-channel counters onto the flat output bus
    always_comb begin
        edge_count = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            edge_count[c*CNT_W +: CNT_W] = r_cnt[c];
        end
    end

    assign d_filt   = r_filt;
    assign d_edge   = r_edge;
    assign any_edge = |r_edge;

endmodule

// File: tb/tb_usb_edge_detect_multi.sv
// tb_usb_edge_detect_multi
// Directed, table-driven bench for usb_edge_detect_multi with NUM_CH=2, FILTER_LEN=3,
// CNT_W=4, IDLE_VAL=1. It uses hand-written sequences for saturation, clear and mid-filter reset.

module tb_usb_edge_detect_multi;

    logic       clk;
    logic       n_rst;
    logic [1:0] d_in;
    logic [3:0] mode;
    logic [1:0] cnt_clr;
    logic [1:0] d_filt;
    logic [1:0] d_edge;
    logic       any_edge;
    logic [7:0] edge_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] din;
        logic [3:0] md;
        logic [1:0] clr;
        logic [1:0] expFilt;
        logic [1:0] expEdge;
        logic       expAny;
        logic [7:0] expCnt;
    } vec_t;

    vec_t vecs [36];

    usb_edge_detect_multi #(
        .NUM_CH(2),
        .FILTER_LEN(3),
        .CNT_W(4),
        .IDLE_VAL(1'b1)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .d_in(d_in),
        .mode(mode),
        .cnt_clr(cnt_clr),
        .d_filt(d_filt),
        .d_edge(d_edge),
        .any_edge(any_edge),
        .edge_count(edge_count)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then settle just after the edge that sampled them
    task automatic applyStimulus(input logic [1:0] din, input logic [3:0] md, input logic [1:0] clr);
        d_in    = din;
        mode    = md;
        cnt_clr = clr;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the expected values
    task automatic checkOutput(input string name, input logic [1:0] expFilt, input logic [1:0] expEdge,
                               input logic expAny, input logic [7:0] expCnt);
        checks++;
        if (d_filt !== expFilt) begin
            errors++;
            $display("[TB] FAIL %s d_filt: got %b expected %b", name, d_filt, expFilt);
        end
        checks++;
        if (d_edge !== expEdge) begin
            errors++;
            $display("[TB] FAIL %s d_edge: got %b expected %b", name, d_edge, expEdge);
        end
        checks++;
        if (any_edge !== expAny) begin
            errors++;
            $display("[TB] FAIL %s any_edge: got %b expected %b", name, any_edge, expAny);
        end
        checks++;
        if (edge_count !== expCnt) begin
            errors++;
            $display("[TB] FAIL %s edge_count: got %h expected %h", name, edge_count, expCnt);
        end
    endtask

    initial begin
        logic [3:0] expCnt1;
        logic       lvl;

        // falling on ch0 with mode both, then return high
        vecs[0]  = '{2'b10, 4'b1111, 2'b00, 2'b11, 2'b00, 1'b0, 8'h00};
        vecs[1]  = '{2'b10, 4'b1111, 2'b00, 2'b11, 2'b00, 1'b0, 8'h00};
        vecs[2]  = '{2'b10, 4'b1111, 2'b00, 2'b10, 2'b01, 1'b1, 8'h01};
        vecs[3]  = '{2'b10, 4'b1111, 2'b00, 2'b10, 2'b00, 1'b0, 8'h01};
        vecs[4]  = '{2'b11, 4'b1111, 2'b00, 2'b10, 2'b00, 1'b0, 8'h01};
        vecs[5]  = '{2'b11, 4'b1111, 2'b00, 2'b10, 2'b00, 1'b0, 8'h01};
        vecs[6]  = '{2'b11, 4'b1111, 2'b00, 2'b11, 2'b01, 1'b1, 8'h02};
        // two-cycle glitch rejected, three-cycle low accepted
        vecs[7]  = '{2'b10, 4'b1111, 2'b00, 2'b11, 2'b00, 1'b0, 8'h02};
        vecs[8]  = '{2'b10, 4'b1111, 2'b00, 2'b11, 2'b00, 1'b0, 8'h02};
        vecs[9]  = '{2'b11, 4'b1111, 2'b00, 2'b11, 2'b00, 1'b0, 8'h02};
        vecs[10] = '{2'b11, 4'b1111, 2'b00, 2'b11, 2'b00, 1'b0, 8'h02};
        vecs[11] = '{2'b10, 4'b1111, 2'b00, 2'b11, 2'b00, 1'b0, 8'h02};
        vecs[12] = '{2'b10, 4'b1111, 2'b00, 2'b11, 2'b00, 1'b0, 8'h02};
        vecs[13] = '{2'b10, 4'b1111, 2'b00, 2'b10, 2'b01, 1'b1, 8'h03};
        // rising-only on ch0: rise, fall, rise each held 5 cycles
        vecs[14] = '{2'b11, 4'b1101, 2'b00, 2'b10, 2'b00, 1'b0, 8'h03};
        vecs[15] = '{2'b11, 4'b1101, 2'b00, 2'b10, 2'b00, 1'b0, 8'h03};
        vecs[16] = '{2'b11, 4'b1101, 2'b00, 2'b11, 2'b01, 1'b1, 8'h04};
        vecs[17] = '{2'b11, 4'b1101, 2'b00, 2'b11, 2'b00, 1'b0, 8'h04};
        vecs[18] = '{2'b11, 4'b1101, 2'b00, 2'b11, 2'b00, 1'b0, 8'h04};
        vecs[19] = '{2'b10, 4'b1101, 2'b00, 2'b11, 2'b00, 1'b0, 8'h04};
        vecs[20] = '{2'b10, 4'b1101, 2'b00, 2'b11, 2'b00, 1'b0, 8'h04};
        vecs[21] = '{2'b10, 4'b1101, 2'b00, 2'b10, 2'b00, 1'b0, 8'h04};
        vecs[22] = '{2'b10, 4'b1101, 2'b00, 2'b10, 2'b00, 1'b0, 8'h04};
        vecs[23] = '{2'b10, 4'b1101, 2'b00, 2'b10, 2'b00, 1'b0, 8'h04};
        vecs[24] = '{2'b11, 4'b1101, 2'b00, 2'b10, 2'b00, 1'b0, 8'h04};
        vecs[25] = '{2'b11, 4'b1101, 2'b00, 2'b10, 2'b00, 1'b0, 8'h04};
        vecs[26] = '{2'b11, 4'b1101, 2'b00, 2'b11, 2'b01, 1'b1, 8'h05};
        vecs[27] = '{2'b11, 4'b1101, 2'b00, 2'b11, 2'b00, 1'b0, 8'h05};
        vecs[28] = '{2'b11, 4'b1101, 2'b00, 2'b11, 2'b00, 1'b0, 8'h05};
        // mode change alone never pulses
        vecs[29] = '{2'b11, 4'b1110, 2'b00, 2'b11, 2'b00, 1'b0, 8'h05};
        // simultaneous falling edges on both channels
        vecs[30] = '{2'b00, 4'b1111, 2'b00, 2'b11, 2'b00, 1'b0, 8'h05};
        vecs[31] = '{2'b00, 4'b1111, 2'b00, 2'b11, 2'b00, 1'b0, 8'h05};
        vecs[32] = '{2'b00, 4'b1111, 2'b00, 2'b00, 2'b11, 1'b1, 8'h16};
        vecs[33] = '{2'b00, 4'b1111, 2'b00, 2'b00, 2'b00, 1'b0, 8'h16};
        // independent clears
        vecs[34] = '{2'b00, 4'b1111, 2'b01, 2'b00, 2'b00, 1'b0, 8'h10};
        vecs[35] = '{2'b00, 4'b1111, 2'b10, 2'b00, 2'b00, 1'b0, 8'h00};

        // reset with the line low: outputs still show idle
        n_rst   = 1'b0;
        d_in    = 2'b00;
        mode    = 4'b0000;
        cnt_clr = 2'b00;
        #12;
        checkOutput("reset", 2'b11, 2'b00, 1'b0, 8'h00);
        d_in = 2'b11;
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // idle line after release produces nothing
        for (int i = 0; i < 10; i++) begin
            applyStimulus(2'b11, 4'b1111, 2'b00);
            checkOutput($sformatf("idle[%0d]", i), 2'b11, 2'b00, 1'b0, 8'h00);
        end

        // table-driven vectors
        for (int i = 0; i < 36; i++) begin
            applyStimulus(vecs[i].din, vecs[i].md, vecs[i].clr);
            checkOutput($sformatf("vec[%0d]", i), vecs[i].expFilt, vecs[i].expEdge,
                        vecs[i].expAny, vecs[i].expCnt);
        end

        // 20 qualified edges on ch1 saturate its counter at 15
        expCnt1 = 4'd0;
        for (int i = 0; i < 20; i++) begin
            lvl = ((i % 2) == 0);
            for (int j = 0; j < 3; j++) begin
                applyStimulus({lvl, 1'b0}, 4'b1100, 2'b00);
                if (j == 2) begin
                    if (expCnt1 != 4'hF) expCnt1 = expCnt1 + 4'd1;
                    checkOutput($sformatf("sat[%0d]", i), {lvl, 1'b0}, 2'b10, 1'b1, {expCnt1, 4'h0});
                end else begin
                    checkOutput($sformatf("sat[%0d].%0d", i, j), {~lvl, 1'b0}, 2'b00, 1'b0, {expCnt1, 4'h0});
                end
            end
        end
        applyStimulus(2'b00, 4'b1100, 2'b00);
        checkOutput("sat_hold", 2'b00, 2'b00, 1'b0, 8'hF0);

        // clear coinciding with a qualified edge leaves count at 1, then clear alone
        applyStimulus(2'b10, 4'b1100, 2'b00);
        checkOutput("clr_edge.0", 2'b00, 2'b00, 1'b0, 8'hF0);
        applyStimulus(2'b10, 4'b1100, 2'b00);
        checkOutput("clr_edge.1", 2'b00, 2'b00, 1'b0, 8'hF0);
        applyStimulus(2'b10, 4'b1100, 2'b10);
        checkOutput("clr_edge", 2'b10, 2'b10, 1'b1, 8'h10);
        applyStimulus(2'b10, 4'b1100, 2'b10);
        checkOutput("clr_only", 2'b10, 2'b00, 1'b0, 8'h00);

        // bring ch0 high, then start a falling filter and reset in the middle of it
        applyStimulus(2'b11, 4'b1111, 2'b00);
        applyStimulus(2'b11, 4'b1111, 2'b00);
        applyStimulus(2'b11, 4'b1111, 2'b00);
        checkOutput("pre_rst_rise", 2'b11, 2'b01, 1'b1, 8'h01);
        applyStimulus(2'b10, 4'b1111, 2'b00);
        applyStimulus(2'b10, 4'b1111, 2'b00);
        checkOutput("pre_rst_filt", 2'b11, 2'b00, 1'b0, 8'h01);
        n_rst = 1'b0;
        #1;
        checkOutput("mid_rst", 2'b11, 2'b00, 1'b0, 8'h00);
        d_in = 2'b11;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        applyStimulus(2'b11, 4'b1111, 2'b00);
        checkOutput("post_rst.0", 2'b11, 2'b00, 1'b0, 8'h00);
        applyStimulus(2'b11, 4'b1111, 2'b00);
        checkOutput("post_rst.1", 2'b11, 2'b00, 1'b0, 8'h00);

        // a fresh fall needs the full three cycles, proving the filter counter was discarded
        applyStimulus(2'b10, 4'b1111, 2'b00);
        checkOutput("post_rst_fall.0", 2'b11, 2'b00, 1'b0, 8'h00);
        applyStimulus(2'b10, 4'b1111, 2'b00);
        checkOutput("post_rst_fall.1", 2'b11, 2'b00, 1'b0, 8'h00);
        applyStimulus(2'b10, 4'b1111, 2'b00);
        checkOutput("post_rst_fall.2", 2'b10, 2'b01, 1'b1, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
